// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
package hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle between the core stages and the hazard controller
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] Rs1D;
    logic [REG_W-1:0] Rs2D;
    logic [REG_W-1:0] Rs1E;
    logic [REG_W-1:0] Rs2E;
    logic [REG_W-1:0] RdE;
    logic [REG_W-1:0] RdM;
    logic [REG_W-1:0] RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemErr, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemErr, StallCycles
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - execute-stage operand forward select for one source register
module fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rd_m,
    input  logic [REG_W-1:0] i_rd_w,
    input  logic             i_reg_write_m,
    input  logic             i_reg_write_w,
    output logic [1:0]       o_fwd
);

    // M is the younger producer, so it wins over W; x0 never forwards.
    always_comb begin
        o_fwd = FWD_RF;
        if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs)) begin
            o_fwd = FWD_M;
        end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs)) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencing, forwarding and data-memory wait FSM for the 5-stage core
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t            r_state;
    state_t            w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic              w_mem_stall;
    logic              w_lw_stall;
    logic              w_any_stall;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .i_rs          (hz.Rs1E),
        .i_rd_m        (hz.RdM),
        .i_rd_w        (hz.RdW),
        .i_reg_write_m (hz.RegWriteM),
        .i_reg_write_w (hz.RegWriteW),
        .o_fwd         (w_fwd_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .i_rs          (hz.Rs2E),
        .i_rd_m        (hz.RdM),
        .i_rd_w        (hz.RdW),
        .i_reg_write_m (hz.RegWriteM),
        .i_reg_write_w (hz.RegWriteW),
        .o_fwd         (w_fwd_b)
    );

    // The stall is combinational so a ready seen this cycle releases the pipeline immediately.
    always_comb begin
        w_next_state = r_state;
        w_mem_stall  = 1'b0;
        case (r_state)
            RUN: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    w_next_state = MEM_WAIT;
                    w_mem_stall  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (hz.MemReadyM) begin
                    w_next_state = RUN;
                end else begin
                    w_mem_stall = 1'b1;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    assign w_lw_stall = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != '0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_comb begin
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushW    = 1'b0;
        hz.ForwardAE = FWD_RF;
        hz.ForwardBE = FWD_RF;
        if (rst) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
            hz.FlushW = 1'b1;
        end else if (w_mem_stall) begin
            hz.StallF    = 1'b1;
            hz.StallD    = 1'b1;
            hz.StallE    = 1'b1;
            hz.StallM    = 1'b1;
            hz.FlushW    = 1'b1;
            hz.ForwardAE = w_fwd_a;
            hz.ForwardBE = w_fwd_b;
        end else begin
            // A taken branch discards decode, so it cancels the load-use hold of F/D.
            hz.StallF    = w_lw_stall && !hz.PCSrcE;
            hz.StallD    = w_lw_stall && !hz.PCSrcE;
            hz.FlushD    = hz.PCSrcE;
            hz.FlushE    = hz.PCSrcE || w_lw_stall;
            hz.ForwardAE = w_fwd_a;
            hz.ForwardBE = w_fwd_b;
        end
    end

    assign w_any_stall    = hz.StallF || hz.StallD || hz.StallE || hz.StallM;
    assign hz.MemErr      = r_mem_err;
    assign hz.StallCycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == MEM_WAIT && w_next_state == MEM_WAIT) begin
                if (r_wait_cnt == WAIT_LIMIT) begin
                    r_mem_err <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_any_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(3)) hz ();

    hazard_ctrl #(
        .REG_W       (5),
        .MEM_TIMEOUT (4),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE}
    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       regwm, regww;
        logic [1:0] ressrc;
        logic       pcsrc;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [10:0] outs();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW, hz.ForwardAE, hz.ForwardBE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
        hz.MemReqM = 1'b0; hz.MemReadyM = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        set_idle();

        //               name        rs1d rs2d rs1e rs2e rde rdm rdw wm wW  res    br  exp
        vecs[0]  = '{"fwd_m",      0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, {4'b0000, 3'b000, 2'b10, 2'b00}};
        vecs[1]  = '{"fwd_w",      0, 0, 5, 0, 0, 5, 5, 0, 1, 2'b00, 0, {4'b0000, 3'b000, 2'b01, 2'b00}};
        vecs[2]  = '{"fwd_x0",     0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, {4'b0000, 3'b000, 2'b00, 2'b00}};
        vecs[3]  = '{"fwd_rd0",    0, 0, 5, 0, 0, 0, 0, 1, 1, 2'b00, 0, {4'b0000, 3'b000, 2'b00, 2'b00}};
        vecs[4]  = '{"fwd_ab",     0, 0, 3, 9, 0, 3, 9, 1, 1, 2'b00, 0, {4'b0000, 3'b000, 2'b10, 2'b01}};
        vecs[5]  = '{"fwd_both_m", 0, 0, 9, 9, 0, 9, 9, 1, 0, 2'b00, 0, {4'b0000, 3'b000, 2'b10, 2'b10}};
        vecs[6]  = '{"lw_rs2",     0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, {4'b1100, 3'b010, 2'b00, 2'b00}};
        vecs[7]  = '{"lw_rs1",     7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, {4'b1100, 3'b010, 2'b00, 2'b00}};
        vecs[8]  = '{"lw_rd0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, {4'b0000, 3'b000, 2'b00, 2'b00}};
        vecs[9]  = '{"lw_not_ld",  0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b00, 0, {4'b0000, 3'b000, 2'b00, 2'b00}};
        vecs[10] = '{"lw_res10",   0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, {4'b0000, 3'b000, 2'b00, 2'b00}};
        vecs[11] = '{"br_lw",      0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 1, {4'b0000, 3'b110, 2'b00, 2'b00}};
        vecs[12] = '{"br_only",    0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, {4'b0000, 3'b110, 2'b00, 2'b00}};
        vecs[13] = '{"lw_fwd_w",   0, 7, 4, 0, 7, 0, 4, 0, 1, 2'b01, 0, {4'b1100, 3'b010, 2'b01, 2'b00}};

        // Reset with hazards and forwarding sources present on the inputs
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        #2;
        check("rst_outputs", 32'(outs()), 32'({4'b0000, 3'b111, 2'b00, 2'b00}));
        step();
        check("rst_stall_cycles", 32'(hz.StallCycles), 32'd0);
        check("rst_mem_err", 32'(hz.MemErr), 32'd0);
        check("rst_outputs_held", 32'(outs()), 32'({4'b0000, 3'b111, 2'b00, 2'b00}));
        set_idle();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step();
            hz.Rs1D = vecs[i].rs1d; hz.Rs2D = vecs[i].rs2d;
            hz.Rs1E = vecs[i].rs1e; hz.Rs2E = vecs[i].rs2e;
            hz.RdE = vecs[i].rde; hz.RdM = vecs[i].rdm; hz.RdW = vecs[i].rdw;
            hz.RegWriteM = vecs[i].regwm; hz.RegWriteW = vecs[i].regww;
            hz.ResultSrcE = vecs[i].ressrc; hz.PCSrcE = vecs[i].pcsrc;
            #2;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // Memory wait: 3 not-ready cycles then ready, with forwarding live
        step();
        set_idle();
        do_reset();
        hz.Rs1E = 5'd6; hz.RdM = 5'd6; hz.RegWriteM = 1'b1;
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        #2;
        check("mw_c1", 32'(outs()), 32'({4'b1111, 3'b001, 2'b10, 2'b00}));
        step();
        hz.PCSrcE = 1'b1; hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #2;
        check("mw_c2_priority", 32'(outs()), 32'({4'b1111, 3'b001, 2'b10, 2'b00}));
        step();
        hz.PCSrcE = 1'b0; hz.ResultSrcE = 2'b00;
        #2;
        check("mw_c3", 32'(outs()), 32'({4'b1111, 3'b001, 2'b10, 2'b00}));
        step();
        hz.MemReadyM = 1'b1;
        #2;
        check("mw_ready", 32'(outs()), 32'({4'b0000, 3'b000, 2'b10, 2'b00}));
        step();
        hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
        #2;
        check("mw_back_run", 32'(outs()), 32'({4'b0000, 3'b000, 2'b10, 2'b00}));
        check("mw_stall_cycles", 32'(hz.StallCycles), 32'd3);
        check("mw_no_err", 32'(hz.MemErr), 32'd0);

        // Watchdog and counter saturation: 9 not-ready cycles
        step();
        set_idle();
        do_reset();
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("wd_early_err", 32'(hz.MemErr), 32'd0);
        check("wd_cnt3", 32'(hz.StallCycles), 32'd3);
        for (int i = 0; i < 6; i++) step();
        check("wd_err_set", 32'(hz.MemErr), 32'd1);
        check("sat_cnt", 32'(hz.StallCycles), 32'd7);
        check("wd_still_wait", 32'(outs()), 32'({4'b1111, 3'b001, 2'b00, 2'b00}));
        hz.MemReadyM = 1'b1;
        step();
        hz.MemReqM = 1'b0;
        step();
        check("wd_err_sticky", 32'(hz.MemErr), 32'd1);
        check("wd_released", 32'(outs()), 32'd0);
        do_reset();
        check("wd_rst_err", 32'(hz.MemErr), 32'd0);
        check("wd_rst_cnt", 32'(hz.StallCycles), 32'd0);

        // Reset in the middle of a wait abandons the access
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        step();
        step();
        rst = 1'b1;
        #2;
        check("rmw_during_rst", 32'(outs()), 32'({4'b0000, 3'b111, 2'b00, 2'b00}));
        step();
        rst = 1'b0;
        hz.MemReqM = 1'b0;
        #2;
        check("rmw_run", 32'(outs()), 32'd0);
        check("rmw_cnt", 32'(hz.StallCycles), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV32I core. It drives the stall and flush enables of the fetch, decode, execute, memory and writeback pipeline registers, and the execute-stage forwarding selects. It runs a small FSM that holds the pipeline while a memory-stage data access waits on a not-ready data memory, with a wait watchdog and a stall-cycle counter. It sits beside the pipeline registers and sequences them; it holds no datapath values.

Parameters:
REG_W, 5, register-address width compared (upper bits of wider RD fields are ignored)
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before MemErr is set
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
Rs1D, Rs2D  in  REG_W  source regs in decode
Rs1E, Rs2E  in  REG_W  source regs in execute
RdE, RdM, RdW  in  REG_W  destination regs in execute / memory / writeback
RegWriteM, RegWriteW  in  1  register write enable in memory / writeback
ResultSrcE  in  2  result select in execute; 2'b01 = load
PCSrcE  in  1  taken branch/jump resolved in execute
MemReqM  in  1  memory stage performs a data load or store this cycle
MemReadyM  in  1  data memory completes the access this cycle
StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
FlushD, FlushE, FlushW  out  1  load a bubble (all control zero) into the register
ForwardAE, ForwardBE  out  2  00 register file, 01 from W result, 10 from M ALU result
MemErr  out  1  sticky watchdog error
StallCycles  out  CNT_W  saturating count of cycles with any stall asserted

Behaviour:
- FSM states: RUN and MEM_WAIT, held in one state register.
- RUN -> MEM_WAIT when MemReqM=1 and MemReadyM=0. MEM_WAIT -> RUN on MemReadyM=1. All other cases hold the current state.
- memStall = (RUN & MemReqM & !MemReadyM) | (MEM_WAIT & !MemReadyM). It is combinational, so ready releases the stall in the same cycle it is seen.
- memStall=1 drives StallF, StallD, StallE and StallM high and FlushW high. FlushD and FlushE are driven low.
- memStall takes priority over every other hazard. A branch or load-use held in E/D is re-evaluated once the stall is released, because the inputs are held.
- Load-use stall: lwStall = (ResultSrcE==01) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)). It drives StallF=1, StallD=1, FlushE=1.
- Branch: PCSrcE=1 drives FlushD=1 and FlushE=1. A branch overrides lwStall: StallF=0 and StallD=0, because the decode instruction is discarded.
- Forwarding, shown for A; B is identical using Rs2E:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - The M stage takes priority. Forwarding stays valid during MEM_WAIT.
- Watchdog: the wait counter is cleared in RUN and increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT, MemErr is set on the next edge. The FSM stays in MEM_WAIT.
- MemErr is sticky until rst.
- StallCycles increments on any cycle with StallF|StallD|StallE|StallM=1 and saturates at all-ones.
- Reset is synchronous:
  - state returns to RUN; the wait counter, MemErr and StallCycles go to 0;
  - while rst=1, all Stall* outputs are 0, FlushD/FlushE/FlushW are 1 and Forward* are 00;
  - reset mid-MEM_WAIT abandons the access.
- Latency: all stall, flush and forward outputs are combinational from the current inputs and state. Only state, the wait counter, MemErr and StallCycles are registered.

Decomposition:
- Shared package holds:
  - state enum {RUN, MEM_WAIT};
  - forward-select localparams FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RESULT_LOAD=2'b01.
- One sub-module, fwd_sel: a combinational forward-select function instanced for A and B.
- The FSM, watchdog and counter stay in hazard_ctrl.

Test Plan:
- Forward priority: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set Rs1E=0, or both RdM and RdW to 0 -> ForwardAE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. RdE=0 -> no stall.
- Branch with load-use: PCSrcE=1 and the load-use condition in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all four stalls and FlushW high for 3 cycles and low on the ready cycle; StallCycles=3; state back in RUN.
- Watchdog: MEM_TIMEOUT=4, MemReadyM held 0 -> MemErr=1 after 4 wait cycles and stays 1 after MemReadyM=1; rst clears MemErr and StallCycles to 0.
- Reset mid-wait and saturation: rst=1 during MEM_WAIT -> RUN next cycle with stalls 0 after release. CNT_W=3 with 9 stall cycles -> StallCycles=7.
